// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Declarations shared by the UART transmit scheduler:
//   DATA_W            payload width of one requester (7 bits)
//   FRAME_BITS_PAR    bits on the line with parity: start, 7 data, parity, stop
//   FRAME_BITS_NOPAR  bits on the line without parity: start, 7 data, stop
//   state_e           scheduler state (IDLE / SEND)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_W           = 7;
    localparam int FRAME_BITS_PAR   = 10;
    localparam int FRAME_BITS_NOPAR = 9;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts one past the pointer and
// wraps modulo NUM_REQ; the first requesting index wins.
// Ports:
//   req_i  [NUM_REQ-1:0]  request vector
//   ptr_i  [IDX_W-1:0]    index of the previous winner
//   gnt_o  [NUM_REQ-1:0]  one-hot grant (all zero when nothing requests)
//   idx_o  [IDX_W-1:0]    index of the winner (0 when nothing requests)
//   any_o                 at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int  cand;
        logic found;
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment; a path that skips an assignment infers a latch.
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(ptr_i) + off) % NUM_REQ;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Shares one UART TX line between NUM_REQ requesters. One requester is granted
// per frame (round robin); its 7-bit payload is framed as start, data LSB
// first, [even parity], stop and shifted out at CLKS_PER_BIT clocks per bit.
// Build option: define UART_TX_SCHED_PARITY_EN for the 10-bit frame with even
// parity; left undefined the parity bit is omitted (9-bit frame).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid [NUM_REQ]    requester i has a payload
//   req_data  [7*NUM_REQ]  payload of requester i at [7i+6:7i]
//   req_ready [NUM_REQ]    one-hot accept pulse, only in IDLE
//   tx                     serial line, idle high (registered)
//   busy                   frame in progress (registered)
//   grant_id              index of the last granted requester
// ---------------------------------------------------------------------------
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [DATA_W*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int SH_W   = DATA_W + 2;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PAR;
`else
    localparam int FRAME_BITS = FRAME_BITS_NOPAR;
`endif
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        LAST_BIT    = 4'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0]  PTR_RESET   = IDX_W'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [3:0]          bit_q, bit_d;
    logic [SH_W-1:0]     shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [DATA_W-1:0]   win_data;
    logic                par_bit;
    logic                baud_done;
    logic                last_bit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign win_data  = req_data[arb_idx*DATA_W +: DATA_W];
    assign baud_done = (baud_q == '0);
    assign last_bit  = (bit_q == LAST_BIT);

    // Without parity the slot after the data is the stop bit itself.
`ifdef UART_TX_SCHED_PARITY_EN
    assign par_bit = ^win_data;
`else
    assign par_bit = 1'b1;
`endif

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = SEND;
            SEND:    if (baud_done && last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Reset has priority over a same-cycle request, so no accept is shown.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !rst) req_ready = arb_gnt;
    end

    // ---------------- Datapath: counters and shifter ----------------
    // The start bit goes straight into tx_q at the grant; shift_q holds the
    // remaining bits (data, parity/stop, stop) and backfills with idle ones.
    always_comb begin
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        if (state_q == IDLE) begin
            if (arb_any) begin
                ptr_d      = arb_idx;
                grant_id_d = arb_idx;
                baud_d     = BAUD_RELOAD;
                bit_d      = '0;
                shift_d    = {1'b1, par_bit, win_data};
                tx_d       = 1'b0;
                busy_d     = 1'b1;
            end
        end else if (baud_done) begin
            baud_d = BAUD_RELOAD;
            if (last_bit) begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end else begin
                bit_d   = bit_q + 4'd1;
                tx_d    = shift_q[0];
                shift_d = {1'b1, shift_q[SH_W-1:1]};
            end
        end else begin
            baud_d = baud_q - 1'b1;
        end
    end

    // NOTE: every datapath flop is reset, not just the control state, so an
    // abandoned frame leaves no stale counter or shifter contents behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= PTR_RESET;
            grant_id_q <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '1;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
// Directed bench for uart_tx_sched with NUM_REQ=4, CLKS_PER_BIT=4. Follows
// the UART_TX_SCHED_PARITY_EN build option for frame length and parity.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int NUM_REQ = 4;
    localparam int CPB     = 4;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int FRAME_BITS = 10;
`else
    localparam int FRAME_BITS = 9;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;
    localparam int BUDGET    = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [27:0] req_data;
    logic [3:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;

    uart_tx_sched #(
        .NUM_REQ      (NUM_REQ),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_data(input int i, input logic [6:0] d);
        req_data[7*i +: 7] = d;
    endtask

    // Called at the negedge of cycle 1 of a frame; ends in the IDLE cycle.
    task automatic check_frame(input string tag, input logic [6:0] d);
        logic [9:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[7:1] = d;
`ifdef UART_TX_SCHED_PARITY_EN
        bits[8]   = ^d;
`endif
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int c = 0; c < CPB; c++) begin
                check({tag, "_tx"}, tx, bits[b]);
                if (c == 0) check({tag, "_busy"}, busy, 1'b1);
                tick();
            end
        end
        check({tag, "_end_busy"}, busy, 1'b0);
        check({tag, "_end_tx"}, tx, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < BUDGET && busy; n++) tick();
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_grant(input string tag);
        for (int n = 0; n < BUDGET && req_ready == 4'b0; n++) tick();
        check({tag, "_busy_at_grant"}, busy, 1'b0);
    endtask

    initial begin
        int t0;
        int got;
        int last;

        rst       = 1'b1;
        req_valid = 4'b0;
        req_data  = '0;

        // ---- reset state, and reset beating a simultaneous request ----
        repeat (3) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 4'b0);
        check("rst_grant_id", grant_id, 2'd0);
        req_valid = 4'b0001;
        set_data(0, 7'h55);
        #1;
        check("rst_with_valid_ready", req_ready, 4'b0);
        tick();
        check("rst_with_valid_busy", busy, 1'b0);
        rst       = 1'b0;
        req_valid = 4'b0000;
        tick();

        // ---- single request, data 0x55 ----
        req_valid = 4'b0001;
        set_data(0, 7'h55);
        #1;
        check("single_ready", req_ready, 4'b0001);
        tick();
        check("single_ready_one_cycle", req_ready, 4'b0000);
        check("single_grant_id", grant_id, 2'd0);
        req_valid = 4'b0000;
        check_frame("single55", 7'h55);

        // ---- parity case, data 0x07 ----
        tick();
        req_valid = 4'b0001;
        set_data(0, 7'h07);
        #1;
        check("par_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        check_frame("par07", 7'h07);

        // ---- round robin, all four requesting after reset ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_data(i, 7'(8'h11 * (i + 1)));
        req_valid = 4'b1111;
        #1;
        got  = 0;
        last = 0;
        for (int n = 0; n < 5 * (FRAME_CYC + 1) + 20 && got < 5; n++) begin
            if (req_ready != 4'b0) begin
                check("rr_ready", req_ready, 32'd1 << (got % 4));
                if (got > 0) check("rr_spacing", cyc_cnt - last, FRAME_CYC + 1);
                last = cyc_cnt;
                got++;
                tick();
                check("rr_grant_id", grant_id, (got - 1) % 4);
            end else begin
                tick();
            end
        end
        check("rr_count", got, 5);
        req_valid = 4'b0000;
        wait_idle("rr");

        // ---- late arrival: requester 2 raises valid during requester 1's frame ----
        req_valid = 4'b0010;
        set_data(1, 7'h2a);
        #1;
        check("late_first_ready", req_ready, 4'b0010);
        t0 = cyc_cnt;
        tick();
        req_valid = 4'b0000;
        repeat (5) tick();
        req_valid = 4'b0100;
        set_data(2, 7'h33);
        wait_grant("late");
        check("late_ready", req_ready, 4'b0100);
        check("late_spacing", cyc_cnt - t0, FRAME_CYC + 1);
        tick();
        check("late_grant_id", grant_id, 2'd2);
        req_valid = 4'b0000;
        wait_idle("late");

        // ---- reset mid-frame at data bit 3 ----
        req_valid = 4'b0001;
        set_data(0, 7'h3c);
        #1;
        check("mid_first_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        repeat (4 * CPB + 1) tick();
        rst       = 1'b1;
        req_valid = 4'b0011;
        set_data(1, 7'h01);
        #1;
        check("mid_rst_ready", req_ready, 4'b0000);
        tick();
        check("mid_after_rst_tx", tx, 1'b1);
        check("mid_after_rst_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_regrant_ready", req_ready, 4'b0001);
        tick();
        check("mid_regrant_busy", busy, 1'b1);
        req_valid = 4'b0000;
        wait_idle("mid");

        // ---- withdrawn request: requester 3 drops out, requester 1 holds ----
        req_valid = 4'b0010;
        set_data(1, 7'h5a);
        #1;
        check("wd_first_ready", req_ready, 4'b0010);
        t0 = cyc_cnt;
        tick();
        repeat (3) tick();
        req_valid = 4'b1010;
        set_data(3, 7'h7f);
        repeat (8) tick();
        req_valid = 4'b0010;
        wait_grant("wd");
        check("wd_ready", req_ready, 4'b0010);
        check("wd_spacing", cyc_cnt - t0, FRAME_CYC + 1);
        tick();
        req_valid = 4'b0000;
        check("wd_grant_id", grant_id, 2'd1);
        wait_idle("wd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler and serializer that shares one UART transmit line between `NUM_REQ` requesters. Each requester offers a 7-bit payload through a valid/ready handshake. The scheduler grants one requester per frame, builds the frame (start, 7 data bits, parity, stop) and shifts it out serially at `CLKS_PER_BIT` clocks per bit. It sits between the on-chip message sources and the board-level TX pin, above the frame-formatting logic.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `CLKS_PER_BIT`, 16: clocks per serial bit, range 2..65535.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ: bit i high means requester i has a payload.
- `req_data`  in  7*NUM_REQ: payload of requester i at bits [7i+6:7i].
- `req_ready`  out  NUM_REQ: one-hot. High for exactly one cycle when the payload is accepted.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: high while a frame is being shifted.
- `grant_id`  out  $clog2(NUM_REQ): index of the last granted requester.

## Operation
- States: `IDLE` and `SEND`.
- **IDLE:**
  - If any `req_valid` is high, the arbiter picks winner g in the same cycle.
  - `req_ready[g]` is asserted combinationally.
  - At the clock edge the block:
    - latches `req_data[g]` into the shift register;
    - sets `grant_id` to g and updates the round-robin pointer to g;
    - loads the bit counter with 0 and the baud counter with `CLKS_PER_BIT-1`;
    - moves to `SEND`.
  - If no request is valid, it stays in `IDLE`.
- **Arbitration:**
  - The search starts at pointer+1 and wraps modulo `NUM_REQ`.
  - The first valid index wins.
  - Pointer reset value is `NUM_REQ-1`, so requester 0 wins first after reset.
- **Frame order on `tx`:**
  1. start bit = 0;
  2. data[0] through data[6], LSB first;
  3. parity = ^data (even parity);
  4. stop bit = 1.
- **SEND:**
  - The baud counter decrements each cycle.
  - At 0 it reloads `CLKS_PER_BIT-1` and advances to the next bit.
  - After the stop bit's final cycle the block returns to `IDLE`.
- **Handshake rules:**
  - A requester holds `req_valid` and `req_data` stable until it sees its `req_ready`.
  - `req_ready` is never asserted in `SEND`.
  - Dropping `req_valid` before the grant withdraws the request. This is legal.
- Requests arriving during `SEND` wait. They are arbitrated in the first `IDLE` cycle.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0;
  - state `IDLE`;
  - pointer `NUM_REQ-1`.
- `tx` and `busy` are registered.
- Frame start: the grant edge is cycle 0. From cycle 1, `tx`=0 (start bit) and `busy`=1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length on the line: 10·`CLKS_PER_BIT` cycles.
- `busy` falls in the cycle after the stop bit ends, together with the return to `IDLE`.
- Minimum grant-to-grant spacing: 10·`CLKS_PER_BIT`+1 cycles (one `IDLE` cycle between frames).
- Reset mid-frame:
  - the frame is abandoned;
  - `tx`=1 and `busy`=0 in the cycle after the reset edge;
  - the pointer returns to `NUM_REQ-1`;
  - no `req_ready` is issued.
- Simultaneous `rst` and `req_valid`: reset wins and no grant is made.

## Configuration
- Macro: `UART_TX_SCHED_PARITY_EN`.
- **Defined:** 10-bit frame with even parity, as described above.
- **Undefined:**
  - parity bit omitted; frame is start, 7 data, stop (9 bits);
  - frame length 9·`CLKS_PER_BIT`;
  - grant spacing 9·`CLKS_PER_BIT`+1.

## Structure
- Shared package `uart_pkg` holds:
  - `DATA_W`=7;
  - the state enum `IDLE`/`SEND`;
  - frame bit-count constants `FRAME_BITS_PAR`=10 and `FRAME_BITS_NOPAR`=9.
- One natural sub-module: `rr_arbiter`. It is purely combinational: request vector plus pointer in, one-hot grant and index out.
- Counters, shift register and state machine live in the top module.

## Test plan
- **Single request:**
  - stimulus: `CLKS_PER_BIT`=4; `req_valid`=0001, data=7'h55;
  - response: `req_ready`=0001 for one cycle; `tx` sequence 0,1,0,1,0,1,0,1,0,1 (parity 0), each bit held 4 cycles; `busy` high 40 cycles.
- **All four requesting continuously after reset:**
  - response: grant order 0,1,2,3,0; `grant_id` matches; spacing between `req_ready` pulses is 41 cycles.
- **Parity:**
  - stimulus: data=7'h07;
  - response: parity bit 1, stop bit 1. With the macro undefined, no parity bit appears and the frame is 36 cycles.
- **Late arrival:**
  - stimulus: requester 2 asserts `req_valid` during the frame of requester 1;
  - response: requester 2 is granted in the first `IDLE` cycle, with no `req_ready` during `SEND`.
- **Reset mid-frame:**
  - stimulus: `rst` pulsed at data bit 3;
  - response: `tx`=1 and `busy`=0 the next cycle. The next grant goes to requester 0 even if requester 0 was last granted.
- **Withdrawn request:**
  - stimulus: `req_valid`[3] raised then dropped during `SEND`, with `req_valid`[1] held;
  - response: only requester 1 is granted next.
